// File: rtl/rfsoc_ctrl_pkg.sv
// Shared definitions for the RFSoC capture control slice.
//   AXIS_DMA_DATA_W : stream data width feeding the PS S2MM DMA
//   AXIS_DMA_LEN_W  : width of packet-length / packet-count fields and counters
//   dma_state_e     : packetizer FSM state encoding
package rfsoc_ctrl_pkg;

  localparam int unsigned AXIS_DMA_DATA_W = 32;
  localparam int unsigned AXIS_DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StStop  = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream output register (data, last, valid).
//   ps_clk / rst           : clock, asynchronous active-low reset
//   load, load_data/last   : write a new beat into the register
//   out_ready              : downstream accept
//   out_valid/data/last    : registered beat presented downstream
//   up_ready               : register can take a beat this cycle (empty or draining)
module axis_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              ps_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              up_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign up_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      // Data/last are left as-is once drained; only valid qualifies them.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/axis_dma_packetizer.sv
// Packetizes the capture FIFO sample stream into fixed-length AXIS packets for the S2MM DMA.
//   ps_clk / rst              : 100 MHz PS clock, asynchronous active-low reset
//   cfg_len, cfg_num_pkts     : beats per packet / packets per run (0 = until stop)
//   start, stop               : run arm pulse / graceful stop request pulse
//   busy, done, cfg_err       : status (busy outside IDLE, end-of-run pulse, sticky len==0 error)
//   pkt_cnt                   : packets fully accepted by the DMA in this/last run
//   s_axis_*                  : FIFO side (slave)
//   m_axis_*                  : DMA side (master), tkeep constant all-ones
module axis_dma_packetizer
  import rfsoc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DMA_DATA_W,
  parameter int unsigned LEN_W  = AXIS_DMA_LEN_W
) (
  input  logic                ps_clk,
  input  logic                rst,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [LEN_W-1:0]    cfg_num_pkts,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [LEN_W-1:0]    pkt_cnt,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
);

  dma_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] in_pkt_q, in_pkt_d;  // packets completed on the input side
  logic [LEN_W-1:0] pkt_q, pkt_d;        // packets accepted by the DMA
  logic             err_q, err_d;

  logic up_ready;
  logic run_en;
  logic accept;
  logic is_last;
  logic final_pkt;
  logic out_fire_last;

  assign run_en        = (state_q == StRun) || (state_q == StStop);
  assign s_axis_tready = run_en && up_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign is_last       = (beat_q == len_q - LEN_W'(1));
  // Packet count limit is enforced on the input side so no beat past the run is popped.
  assign final_pkt     = (num_q != '0) && (in_pkt_q == num_q - LEN_W'(1));
  assign out_fire_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    num_d    = num_q;
    beat_d   = beat_q;
    in_pkt_d = in_pkt_q;
    pkt_d    = pkt_q;
    err_d    = err_q;

    if (out_fire_last) begin
      pkt_d = pkt_q + LEN_W'(1);
    end

    if (accept) begin
      if (is_last) begin
        beat_d   = '0;
        in_pkt_d = in_pkt_q + LEN_W'(1);
      end else begin
        beat_d = beat_q + LEN_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_len != '0) begin
            len_d    = cfg_len;
            num_d    = cfg_num_pkts;
            pkt_d    = '0;
            beat_d   = '0;
            in_pkt_d = '0;
            err_d    = 1'b0;
            state_d  = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (accept && is_last && (stop || final_pkt)) begin
          state_d = StFlush;
        end else if (stop) begin
          // A beat accepted alongside stop that opens a packet still gets finished.
          state_d = (beat_d != '0) ? StStop : StFlush;
        end
      end
      StStop: begin
        if (accept && is_last) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!m_axis_tvalid || m_axis_tready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      num_q    <= '0;
      beat_q   <= '0;
      in_pkt_q <= '0;
      pkt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      num_q    <= num_d;
      beat_q   <= beat_d;
      in_pkt_q <= in_pkt_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .ps_clk    (ps_clk),
    .rst       (rst),
    .load      (accept),
    .load_data (s_axis_tdata),
    .load_last (is_last),
    .out_ready (m_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .up_ready  (up_ready)
  );

  assign m_axis_tkeep = '1;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign cfg_err      = err_q;
  assign pkt_cnt      = pkt_q;

endmodule

// File: tb/tb_axis_dma_packetizer.sv
// Self-checking bench for axis_dma_packetizer: table of runs checked against a queue-based
// stream model, plus hand sequences for cfg_err and asynchronous reset mid-packet.
module tb_axis_dma_packetizer;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          ps_clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_len, cfg_num_pkts;
  logic          start, stop;
  logic          busy, done, cfg_err;
  logic [LW-1:0] pkt_cnt;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

  axis_dma_packetizer dut (
    .ps_clk        (ps_clk),
    .rst           (rst),
    .cfg_len       (cfg_len),
    .cfg_num_pkts  (cfg_num_pkts),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .pkt_cnt       (pkt_cnt),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 ps_clk = ~ps_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int len;
    int num;
    int stop_at;       // issue stop once this many beats have been popped (0 = never)
    bit idle_at_stop;  // source goes idle from the stop cycle on
    bit rnd;           // random source valid / sink ready
    int exp_beats;
    int exp_pkts;
  } vec_t;

  vec_t vecs[7];

  // Model: the DMA must see exactly the popped words in order, tlast on every len-th beat.
  task automatic run_vec(input vec_t v, input int idx);
    logic [DW-1:0] q[$];
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] sd;
    logic          sl;
    int  pops = 0, outs = 0, dones = 0;
    bit  stop_sent = 0, popped, stall = 0, fin = 0;
    d = DW'(idx) << 16;
    cfg_len      = LW'(v.len);
    cfg_num_pkts = LW'(v.num);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start = (cyc == 0);
      stop  = 1'b0;
      if (v.stop_at != 0 && !stop_sent && pops == v.stop_at) begin
        stop      = 1'b1;
        stop_sent = 1;
      end
      s_axis_tvalid = (cyc > 0) && !(v.idle_at_stop && stop_sent) &&
                      (v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      m_axis_tready = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata  = d;
      @(negedge ps_clk);
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("cfg_err_cleared", cfg_err, 0);
      end
      if (stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, sd);
        chk("stall_last", m_axis_tlast, sl);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          exp_d = q.pop_front();
          chk("beat_data", m_axis_tdata, exp_d);
          chk("beat_last", m_axis_tlast, ((outs + 1) % v.len) == 0);
        end
        outs++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      sd    = m_axis_tdata;
      sl    = m_axis_tlast;
      popped = s_axis_tvalid && s_axis_tready;
      if (popped) begin
        q.push_back(d);
        pops++;
      end
      if (done) begin
        dones++;
        fin = 1;
      end
      @(posedge ps_clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (popped) d++;
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("out_beats", outs, v.exp_beats);
    chk("popped_beats", pops, v.exp_beats);
    chk("pkt_cnt", pkt_cnt, LW'(v.exp_pkts));
    chk("done_pulses", dones, 1);
    chk("model_drained", q.size(), 0);
    @(negedge ps_clk);
    chk("busy_low_after", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("tready_idle", s_axis_tready, 0);
    @(posedge ps_clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{len: 4, num: 3, stop_at: 0, idle_at_stop: 0, rnd: 0, exp_beats: 12, exp_pkts: 3};
    vecs[1] = '{len: 1, num: 2, stop_at: 0, idle_at_stop: 0, rnd: 0, exp_beats: 2,  exp_pkts: 2};
    vecs[2] = '{len: 8, num: 0, stop_at: 4, idle_at_stop: 0, rnd: 0, exp_beats: 8,  exp_pkts: 1};
    vecs[3] = '{len: 4, num: 5, stop_at: 0, idle_at_stop: 0, rnd: 1, exp_beats: 20, exp_pkts: 5};
    vecs[4] = '{len: 2, num: 0, stop_at: 4, idle_at_stop: 1, rnd: 0, exp_beats: 4,  exp_pkts: 2};
    vecs[5] = '{len: 4, num: 1, stop_at: 0, idle_at_stop: 0, rnd: 0, exp_beats: 4,  exp_pkts: 1};
    vecs[6] = '{len: 3, num: 4, stop_at: 0, idle_at_stop: 0, rnd: 1, exp_beats: 12, exp_pkts: 4};

    rst = 1'b0;
    cfg_len = '0;
    cfg_num_pkts = '0;
    start = 1'b0;
    stop = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #2;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("tkeep_ones", m_axis_tkeep, 4'hF);
    @(negedge ps_clk);
    rst = 1'b1;
    @(posedge ps_clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        // start with zero length: error flag, no run
        cfg_len = '0;
        cfg_num_pkts = LW'(2);
        start = 1'b1;
        @(posedge ps_clk);
        #1;
        start = 1'b0;
        @(negedge ps_clk);
        chk("cfg_err_set", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        @(negedge ps_clk);
        chk("cfg_err_sticky", cfg_err, 1);
        @(posedge ps_clk);
        #1;
      end
      if (i == 5) begin
        // reset in the middle of an unbounded run
        cfg_len = LW'(4);
        cfg_num_pkts = '0;
        s_axis_tdata = 32'hA5A5_0001;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        start = 1'b1;
        @(posedge ps_clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge ps_clk);
        #1;
        chk("pre_rst_pkt_cnt", pkt_cnt, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_tready", s_axis_tready, 0);
        chk("arst_tlast", m_axis_tlast, 0);
        chk("arst_tdata", m_axis_tdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pkt_cnt", pkt_cnt, 0);
        chk("arst_tkeep", m_axis_tkeep, 4'hF);
        s_axis_tvalid = 1'b0;
        @(negedge ps_clk);
        rst = 1'b1;
        @(posedge ps_clk);
        #1;
      end
      run_vec(vecs[i], i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_dma_packetizer.md
# axis_dma_packetizer

Sequences the 32-bit sample stream from the capture FIFO into fixed-length AXI4-Stream packets for the PS S2MM DMA. Replaces the always-valid, always-last pass-through in front of the DMA. Software arms a run with a packet length and a packet count; the block gates the FIFO, generates `tlast` on the final beat of each packet, and reports progress. It sits between the capture FIFO master port and the DMA slave port in the 100 MHz PS clock domain.

## Interface
- `DATA_W`, 32, stream data width; `tkeep` width is `DATA_W/8`
- `LEN_W`, 16, width of the packet-length and packet-count fields and counters

- `ps_clk`  in  1  sole clock, 100 MHz
- `rst`  in  1  asynchronous, active-low reset
- `cfg_len`  in  LEN_W  beats per packet; sampled on an accepted `start`
- `cfg_num_pkts`  in  LEN_W  packets per run; 0 = run until `stop`; sampled on an accepted `start`
- `start`  in  1  single-cycle pulse that arms a run
- `stop`  in  1  single-cycle pulse that requests a graceful end of the run
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  single-cycle pulse when a run ends
- `cfg_err`  out  1  sticky; set by a `start` with `cfg_len`==0; cleared by the next accepted `start`
- `pkt_cnt`  out  LEN_W  packets fully emitted in the current or last run
- `s_axis_tdata`  in  DATA_W  data from the FIFO
- `s_axis_tvalid`  in  1  FIFO data valid
- `s_axis_tready`  out  1  FIFO pop
- `m_axis_tdata`  out  DATA_W  data to the DMA
- `m_axis_tkeep`  out  DATA_W/8  constant all-ones
- `m_axis_tlast`  out  1  high on the last beat of each packet
- `m_axis_tvalid`  out  1  output beat valid
- `m_axis_tready`  in  1  DMA accept

## Operation
- FSM states: IDLE, RUN, STOP, FLUSH, DONE.
- IDLE:
  - `start` with `cfg_len`≠0 latches `cfg_len` and `cfg_num_pkts`, clears `pkt_cnt`, clears the beat counter and `cfg_err`, then moves to RUN.
  - `start` with `cfg_len`==0 sets `cfg_err` and stays in IDLE.
  - `stop` is ignored.
- `start` is ignored in all non-IDLE states.
- RUN and STOP, input acceptance:
  - `s_axis_tready = !m_axis_tvalid || m_axis_tready`.
  - In IDLE, FLUSH and DONE, `s_axis_tready` = 0.
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`. It loads the output register, with `tlast` = (beat_cnt == len−1).
  - After a non-last beat, beat_cnt increments.
  - After the last beat, beat_cnt returns to 0.
- `pkt_cnt` increments when an output beat with `tlast` is accepted by the DMA (`m_axis_tvalid && m_axis_tready && m_axis_tlast`).
- RUN → STOP on `stop` when beat_cnt≠0 (mid-packet).
- RUN → FLUSH in either of these cases:
  - `stop` arrives while beat_cnt==0.
  - The accepted beat is the last beat of packet number `cfg_num_pkts` (`cfg_num_pkts`≠0).
- STOP continues accepting input. It moves to FLUSH when the last beat of the current packet is accepted.
- FLUSH waits until the output register is empty (`m_axis_tvalid`==0, or drains this cycle), then moves to DONE.
- DONE asserts `done` for one cycle and returns to IDLE.
- If `stop` coincides with the last-beat acceptance in RUN, the transition is RUN → FLUSH directly. No extra packet is started.
- Counters are LEN_W bits. `cfg_len` = 2^LEN_W−1 is the largest packet; no wrap is possible inside a packet.
- With `cfg_num_pkts`=0, `pkt_cnt` wraps modulo 2^LEN_W and the run continues.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `cfg_err`=0, `pkt_cnt`=0. `m_axis_tkeep` is all-ones at all times.
- Latency: an input beat accepted at edge N is presented on `m_axis_*` after edge N, giving 1 cycle of latency.
- Full throughput: 1 beat/cycle with `m_axis_tready` held high.
- AXIS rules: `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid && !m_axis_tready`. Once `m_axis_tvalid` is asserted, it drops only after acceptance.
- `busy` rises the cycle after an accepted `start` and falls the cycle after DONE.
- `done` is high exactly one cycle, in DONE.
- Reset asserted mid-packet aborts immediately. The partial packet is lost, and the DMA must be reset by software.

## Structure
- Shared package `rfsoc_ctrl_pkg`:
  - FSM state enum: IDLE, RUN, STOP, FLUSH, DONE.
  - `AXIS_DMA_DATA_W` = 32.
  - `AXIS_DMA_LEN_W` = 16.
- One sub-module, `axis_out_reg`: a single-stage AXIS output register holding data, last and valid. It generates the upstream ready term.
- The FSM, counters and status logic live in the top level.

## Test plan
- `cfg_len`=4, `cfg_num_pkts`=3, source and sink always ready, data 0..11 → 12 beats with `tlast` on data 3, 7 and 11. `pkt_cnt`=3. One `done` pulse. `busy` low afterwards.
- `cfg_len`=1, `cfg_num_pkts`=2 → `tlast` on every beat. Run ends after 2 beats.
- `cfg_len`=8, `cfg_num_pkts`=0, `stop` after beat 3 → packet completes at beat 7 with `tlast`. `pkt_cnt`=1. No further input popped.
- `cfg_len`=4 with random `m_axis_tready` and `s_axis_tvalid` → beats are in order. Outputs are stable while stalled. `tlast` every 4th beat.
- `start` with `cfg_len`=0 → `cfg_err`=1, `busy`=0. A later valid `start` clears `cfg_err`.
- `rst` low mid-packet → all outputs reach their reset values asynchronously. A new `start` yields a clean packet from beat 0.
